// File: rtl/nibble_serial_adder_pkg.sv
// Shared constants and state encoding for the nibble-serial adder.
// Latency/backpressure: n/a (definitions only).
package nibble_serial_adder_pkg;

  localparam int NIBBLE_W      = 4;
  localparam int DEFAULT_WIDTH = 16;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  function automatic int nibble_count(input int width);
    return width / NIBBLE_W;
  endfunction

endpackage

// File: rtl/nibble_serial_adder_if.sv
// Controller-side handshake and operand/result bus of the nibble-serial adder.
// master drives start/operands; slave (the adder) returns busy/done/result.
interface nibble_serial_adder_if
  import nibble_serial_adder_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
);

  logic             start;
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic             Cin;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] S;
  logic             Carry;

  modport master (
    output start, A, B, Cin,
    input  busy, done, S, Carry
  );

  modport slave (
    input  start, A, B, Cin,
    output busy, done, S, Carry
  );

endinterface

// File: rtl/fb_rca_slice.sv
// 4-bit combinational ripple-carry adder made of four full-adder cells.
// Latency: zero cycles, purely combinational.
module fb_rca_slice
  import nibble_serial_adder_pkg::*;
(
  input  logic [NIBBLE_W-1:0] A,
  input  logic [NIBBLE_W-1:0] B,
  input  logic                C,
  output logic [NIBBLE_W-1:0] S,
  output logic                Carry
);

  logic [NIBBLE_W:0] c_chain;

  assign c_chain[0] = C;

  for (genvar i = 0; i < NIBBLE_W; i++) begin : g_fa
    assign S[i]           = A[i] ^ B[i] ^ c_chain[i];
    assign c_chain[i + 1] = (A[i] & B[i]) | (c_chain[i] & (A[i] ^ B[i]));
  end

  assign Carry = c_chain[NIBBLE_W];

endmodule

// File: rtl/nibble_serial_adder.sv
// WIDTH-bit adder that pushes one nibble per cycle through a shared 4-bit slice.
// Latency NIBBLES cycles after start; start ignored while busy or done.
module nibble_serial_adder
  import nibble_serial_adder_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input logic                  clk,
  input logic                  rst,
  nibble_serial_adder_if.slave bus
);

  localparam int                NIBBLES  = nibble_count(WIDTH);
  localparam int                IDX_W    = $clog2(NIBBLES);
  localparam logic [IDX_W-1:0]  LAST_IDX = IDX_W'(NIBBLES - 1);

  state_e             state_q, state_d;
  logic [WIDTH-1:0]   a_q, a_d;
  logic [WIDTH-1:0]   b_q, b_d;
  logic [WIDTH-1:0]   res_q, res_d;
  logic [WIDTH-1:0]   s_q, s_d;
  logic               carry_q, carry_d;
  logic               cout_q, cout_d;
  logic [IDX_W-1:0]   idx_q, idx_d;

  logic [NIBBLE_W-1:0] slice_a;
  logic [NIBBLE_W-1:0] slice_b;
  logic [NIBBLE_W-1:0] slice_s;
  logic                slice_c;

  assign slice_a = a_q[int'(idx_q) * NIBBLE_W +: NIBBLE_W];
  assign slice_b = b_q[int'(idx_q) * NIBBLE_W +: NIBBLE_W];

  fb_rca_slice u_slice (
    .A     (slice_a),
    .B     (slice_b),
    .C     (carry_q),
    .S     (slice_s),
    .Carry (slice_c)
  );

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    res_d   = res_q;
    s_d     = s_q;
    carry_d = carry_q;
    cout_d  = cout_q;
    idx_d   = idx_q;

    case (state_q)
      IDLE: begin
        if (bus.start) begin
          a_d     = bus.A;
          b_d     = bus.B;
          carry_d = bus.Cin;
          idx_d   = '0;
          state_d = RUN;
        end
      end
      RUN: begin
        res_d[int'(idx_q) * NIBBLE_W +: NIBBLE_W] = slice_s;
        carry_d = slice_c;
        // S/Carry only move here so no partial sum ever reaches the outputs.
        if (idx_q == LAST_IDX) begin
          s_d     = res_d;
          cout_d  = slice_c;
          idx_d   = '0;
          state_d = DONE;
        end else begin
          idx_d = idx_q + IDX_W'(1);
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      res_q   <= '0;
      s_q     <= '0;
      carry_q <= 1'b0;
      cout_q  <= 1'b0;
      idx_q   <= '0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      res_q   <= res_d;
      s_q     <= s_d;
      carry_q <= carry_d;
      cout_q  <= cout_d;
      idx_q   <= idx_d;
    end
  end

  assign bus.busy  = (state_q == RUN);
  assign bus.done  = (state_q == DONE);
  assign bus.S     = s_q;
  assign bus.Carry = cout_q;

endmodule
